// File: rtl/tap_ctrl.sv
// IEEE 1149.1 TAP controller with 4-bit instruction register, one-hot select decode and TDO mux.
// Define TAP_STATE_DBG_EN to expose the encoded FSM state on TAP_STATE[3:0].
module tap_ctrl #(
  parameter int              IR_W        = 4,
  parameter logic [IR_W-1:0] OP_EXTEST   = 4'h0,
  parameter logic [IR_W-1:0] OP_IDCODE   = 4'h1,
  parameter logic [IR_W-1:0] OP_SAMPLE   = 4'h2,
  parameter logic [IR_W-1:0] OP_INTEST   = 4'h3,
  parameter logic [IR_W-1:0] OP_USERCODE = 4'h4,
  parameter logic [IR_W-1:0] OP_RUNBIST  = 4'h5,
  parameter logic [IR_W-1:0] OP_GETTEST  = 4'h6,
  parameter logic [IR_W-1:0] IR_CAPTURE  = 4'b0101
) (
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       ID_REG_TDO,
  input  logic       USERCODE_REG_TDO,
  input  logic       BSR_TDO,
  input  logic       BIST_TDO,
  output logic       CAPTUREDR,
  output logic       SHIFTDR,
  output logic       UPDATEDR,
  output logic       IDCODE_SELECT,
  output logic       SAMPLE_SELECT,
  output logic       EXTEST_SELECT,
  output logic       INTEST_SELECT,
  output logic       USERCODE_SELECT,
  output logic       RUNBIST_SELECT,
  output logic       GETTEST_SELECT,
  output logic       TDO,
  output logic       TDO_EN
`ifdef TAP_STATE_DBG_EN
  ,
  output logic [3:0] TAP_STATE
`endif
);

  // Standard 1149.1 state encoding
  localparam logic [3:0] ST_EX2_DR   = 4'h0;
  localparam logic [3:0] ST_EX1_DR   = 4'h1;
  localparam logic [3:0] ST_SHIFT_DR = 4'h2;
  localparam logic [3:0] ST_PAUSE_DR = 4'h3;
  localparam logic [3:0] ST_SEL_IR   = 4'h4;
  localparam logic [3:0] ST_UPD_DR   = 4'h5;
  localparam logic [3:0] ST_CAP_DR   = 4'h6;
  localparam logic [3:0] ST_SEL_DR   = 4'h7;
  localparam logic [3:0] ST_EX2_IR   = 4'h8;
  localparam logic [3:0] ST_EX1_IR   = 4'h9;
  localparam logic [3:0] ST_SHIFT_IR = 4'hA;
  localparam logic [3:0] ST_PAUSE_IR = 4'hB;
  localparam logic [3:0] ST_RTI      = 4'hC;
  localparam logic [3:0] ST_UPD_IR   = 4'hD;
  localparam logic [3:0] ST_CAP_IR   = 4'hE;
  localparam logic [3:0] ST_TLR      = 4'hF;

  localparam int SEL_IDCODE   = 0;
  localparam int SEL_SAMPLE   = 1;
  localparam int SEL_EXTEST   = 2;
  localparam int SEL_INTEST   = 3;
  localparam int SEL_USERCODE = 4;
  localparam int SEL_RUNBIST  = 5;
  localparam int SEL_GETTEST  = 6;
  localparam logic [6:0] SEL_RESET = 7'b0000001;

  logic [3:0]      state_q, state_d;
  logic [IR_W-1:0] ir_sh_q, ir_sh_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [6:0]      sel_q, sel_d;
  logic            bypass_q, bypass_d;
  logic            tdo_q, tdo_d;
  logic            tdo_en_q, tdo_en_d;
  logic            byp_sel;
  logic            dr_tdo;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:      state_d = TMS ? ST_TLR    : ST_RTI;
      ST_RTI:      state_d = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR:   state_d = TMS ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR:   state_d = TMS ? ST_EX1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: state_d = TMS ? ST_EX1_DR : ST_SHIFT_DR;
      ST_EX1_DR:   state_d = TMS ? ST_UPD_DR : ST_PAUSE_DR;
      ST_PAUSE_DR: state_d = TMS ? ST_EX2_DR : ST_PAUSE_DR;
      ST_EX2_DR:   state_d = TMS ? ST_UPD_DR : ST_SHIFT_DR;
      ST_UPD_DR:   state_d = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR:   state_d = TMS ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR:   state_d = TMS ? ST_EX1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: state_d = TMS ? ST_EX1_IR : ST_SHIFT_IR;
      ST_EX1_IR:   state_d = TMS ? ST_UPD_IR : ST_PAUSE_IR;
      ST_PAUSE_IR: state_d = TMS ? ST_EX2_IR : ST_PAUSE_IR;
      ST_EX2_IR:   state_d = TMS ? ST_UPD_IR : ST_SHIFT_IR;
      ST_UPD_IR:   state_d = TMS ? ST_SEL_DR : ST_RTI;
      default:     state_d = ST_TLR;
    endcase
  end

  // Selects decode the next latch value so they line up with the IR latch itself.
  always_comb begin
    ir_sh_d = ir_sh_q;
    if (state_q == ST_CAP_IR)        ir_sh_d = IR_CAPTURE;
    else if (state_q == ST_SHIFT_IR) ir_sh_d = {TDI, ir_sh_q[IR_W-1:1]};

    ir_d = ir_q;
    if (state_q == ST_UPD_IR)   ir_d = ir_sh_q;
    else if (state_q == ST_TLR) ir_d = OP_IDCODE;

    sel_d = '0;
    case (ir_d)
      OP_IDCODE:   sel_d[SEL_IDCODE]   = 1'b1;
      OP_SAMPLE:   sel_d[SEL_SAMPLE]   = 1'b1;
      OP_EXTEST:   sel_d[SEL_EXTEST]   = 1'b1;
      OP_INTEST:   sel_d[SEL_INTEST]   = 1'b1;
      OP_USERCODE: sel_d[SEL_USERCODE] = 1'b1;
      OP_RUNBIST:  sel_d[SEL_RUNBIST]  = 1'b1;
      OP_GETTEST:  sel_d[SEL_GETTEST]  = 1'b1;
      default:     sel_d = '0;
    endcase
  end

  assign byp_sel = (sel_q == '0);

  always_comb begin
    bypass_d = bypass_q;
    if (byp_sel) begin
      if (state_q == ST_CAP_DR)        bypass_d = 1'b0;
      else if (state_q == ST_SHIFT_DR) bypass_d = TDI;
    end
  end

  always_comb begin
    if (sel_q[SEL_IDCODE])        dr_tdo = ID_REG_TDO;
    else if (sel_q[SEL_USERCODE]) dr_tdo = USERCODE_REG_TDO;
    else if (sel_q[SEL_RUNBIST])  dr_tdo = BIST_TDO;
    else if (sel_q[SEL_SAMPLE] || sel_q[SEL_EXTEST] ||
             sel_q[SEL_INTEST] || sel_q[SEL_GETTEST]) dr_tdo = BSR_TDO;
    else                          dr_tdo = bypass_q;
  end

  always_comb begin
    tdo_d    = tdo_q;
    tdo_en_d = 1'b0;
    if (state_q == ST_SHIFT_IR) begin
      tdo_d    = ir_sh_q[0];
      tdo_en_d = 1'b1;
    end else if (state_q == ST_SHIFT_DR) begin
      tdo_d    = dr_tdo;
      tdo_en_d = 1'b1;
    end
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      state_q  <= ST_TLR;
      ir_sh_q  <= IR_CAPTURE;
      ir_q     <= OP_IDCODE;
      sel_q    <= SEL_RESET;
      bypass_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_sh_q  <= ir_sh_d;
      ir_q     <= ir_d;
      sel_q    <= sel_d;
      bypass_q <= bypass_d;
    end
  end

  // TDO launches on the falling edge so the downstream device samples it on the rising edge.
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign CAPTUREDR       = (state_q == ST_CAP_DR);
  assign SHIFTDR         = (state_q == ST_SHIFT_DR);
  assign UPDATEDR        = (state_q == ST_UPD_DR);
  assign IDCODE_SELECT   = sel_q[SEL_IDCODE];
  assign SAMPLE_SELECT   = sel_q[SEL_SAMPLE];
  assign EXTEST_SELECT   = sel_q[SEL_EXTEST];
  assign INTEST_SELECT   = sel_q[SEL_INTEST];
  assign USERCODE_SELECT = sel_q[SEL_USERCODE];
  assign RUNBIST_SELECT  = sel_q[SEL_RUNBIST];
  assign GETTEST_SELECT  = sel_q[SEL_GETTEST];
  assign TDO             = tdo_q;
  assign TDO_EN          = tdo_en_q;
`ifdef TAP_STATE_DBG_EN
  assign TAP_STATE       = state_q;
`endif

endmodule

// File: tb/tb_tap_ctrl.sv
// Randomized and directed bench for tap_ctrl against a table-driven TAP reference model.
module tb_tap_ctrl;

  logic TCK = 1'b0;
  logic TRST, TMS, TDI, ID_REG_TDO, USERCODE_REG_TDO, BSR_TDO, BIST_TDO;
  logic CAPTUREDR, SHIFTDR, UPDATEDR, TDO, TDO_EN;
  logic IDCODE_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT;
  logic USERCODE_SELECT, RUNBIST_SELECT, GETTEST_SELECT;
`ifdef TAP_STATE_DBG_EN
  logic [3:0] TAP_STATE;
`endif

  tap_ctrl dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
    .ID_REG_TDO(ID_REG_TDO), .USERCODE_REG_TDO(USERCODE_REG_TDO),
    .BSR_TDO(BSR_TDO), .BIST_TDO(BIST_TDO),
    .CAPTUREDR(CAPTUREDR), .SHIFTDR(SHIFTDR), .UPDATEDR(UPDATEDR),
    .IDCODE_SELECT(IDCODE_SELECT), .SAMPLE_SELECT(SAMPLE_SELECT),
    .EXTEST_SELECT(EXTEST_SELECT), .INTEST_SELECT(INTEST_SELECT),
    .USERCODE_SELECT(USERCODE_SELECT), .RUNBIST_SELECT(RUNBIST_SELECT),
    .GETTEST_SELECT(GETTEST_SELECT),
    .TDO(TDO), .TDO_EN(TDO_EN)
`ifdef TAP_STATE_DBG_EN
    , .TAP_STATE(TAP_STATE)
`endif
  );

  // ---------------- clock ----------------
  always #5 TCK = ~TCK;

  // ---------------- reference model ----------------
  // Model states numbered in listing order: TLR RTI SEL_DR CAP_DR SHIFT_DR EX1_DR PAUSE_DR
  // EX2_DR UPD_DR SEL_IR CAP_IR SHIFT_IR EX1_IR PAUSE_IR EX2_IR UPD_IR.
  localparam int M_TLR = 0, M_CAP_DR = 3, M_SHIFT_DR = 4, M_UPD_DR = 8;
  localparam int M_CAP_IR = 10, M_SHIFT_IR = 11, M_UPD_IR = 15;
  int         nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int         nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  logic [3:0] enc  [16] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                            4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};

  int         m_state;
  logic [3:0] m_sh, m_ir;
  logic [6:0] m_sel;   // {GETTEST,RUNBIST,USERCODE,INTEST,EXTEST,SAMPLE,IDCODE}
  logic       m_byp, m_tdo, m_en;

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [0:0] exp_q[$];
  logic       obs_tdo;
  int         cap_cnt, shd_cnt, upd_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] sel_of(input logic [3:0] op);
    case (op)
      4'h1:    return 7'b0000001;
      4'h2:    return 7'b0000010;
      4'h0:    return 7'b0000100;
      4'h3:    return 7'b0001000;
      4'h4:    return 7'b0010000;
      4'h5:    return 7'b0100000;
      4'h6:    return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] dut_sel();
    return {GETTEST_SELECT, RUNBIST_SELECT, USERCODE_SELECT, INTEST_SELECT,
            EXTEST_SELECT, SAMPLE_SELECT, IDCODE_SELECT};
  endfunction

  task automatic model_reset();
    m_state = M_TLR; m_ir = 4'h1; m_sh = 4'h5; m_byp = 1'b0;
    m_sel = sel_of(4'h1); m_tdo = 1'b0; m_en = 1'b0;
  endtask

  task automatic model_posedge(input logic tms, input logic tdi);
    logic [3:0] sh_n, ir_n;
    logic       byp_n;
    sh_n = m_sh; ir_n = m_ir; byp_n = m_byp;
    if (m_state == M_CAP_IR)        sh_n = 4'h5;
    else if (m_state == M_SHIFT_IR) sh_n = (m_sh >> 1) | (4'(tdi) << 3);
    if (m_state == M_UPD_IR)   ir_n = m_sh;
    else if (m_state == M_TLR) ir_n = 4'h1;
    if (m_sel == 7'd0) begin
      if (m_state == M_CAP_DR)        byp_n = 1'b0;
      else if (m_state == M_SHIFT_DR) byp_n = tdi;
    end
    m_state = tms ? nxt1[m_state] : nxt0[m_state];
    m_sh = sh_n; m_ir = ir_n; m_byp = byp_n; m_sel = sel_of(ir_n);
  endtask

  task automatic model_negedge();
    m_en = (m_state == M_SHIFT_IR) || (m_state == M_SHIFT_DR);
    if (m_state == M_SHIFT_IR) m_tdo = m_sh[0];
    else if (m_state == M_SHIFT_DR) begin
      if (m_sel[0])      m_tdo = ID_REG_TDO;
      else if (m_sel[4]) m_tdo = USERCODE_REG_TDO;
      else if (m_sel[5]) m_tdo = BIST_TDO;
      else if (m_sel != 7'd0) m_tdo = BSR_TDO;
      else               m_tdo = m_byp;
    end
  endtask

  task automatic check_post();
    check_eq("capturedr", CAPTUREDR, m_state == M_CAP_DR);
    check_eq("shiftdr",   SHIFTDR,   m_state == M_SHIFT_DR);
    check_eq("updatedr",  UPDATEDR,  m_state == M_UPD_DR);
    check_eq("selects",   dut_sel(), m_sel);
`ifdef TAP_STATE_DBG_EN
    check_eq("tap_state", TAP_STATE, enc[m_state]);
`endif
    if (CAPTUREDR) cap_cnt++;
    if (SHIFTDR)   shd_cnt++;
    if (UPDATEDR)  upd_cnt++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_capdr"}, CAPTUREDR, 1'b0);
    check_eq({tag, "_shdr"},  SHIFTDR,   1'b0);
    check_eq({tag, "_upddr"}, UPDATEDR,  1'b0);
    check_eq({tag, "_sel"},   dut_sel(), 7'b0000001);
    check_eq({tag, "_tdo"},   TDO,       1'b0);
    check_eq({tag, "_tdoen"}, TDO_EN,    1'b0);
  endtask

  // ---------------- driver tasks ----------------
  // Entered just after a rising edge; returns just after the next rising edge.
  task automatic tick(input logic tms, input logic tdi);
    TMS = tms; TDI = tdi;
    ID_REG_TDO       = 1'($urandom_range(0, 1));
    USERCODE_REG_TDO = 1'($urandom_range(0, 1));
    BSR_TDO          = 1'($urandom_range(0, 1));
    BIST_TDO         = 1'($urandom_range(0, 1));
    @(negedge TCK);
    model_negedge();
    #1;
    obs_tdo = TDO;
    check_eq("tdo", TDO, m_tdo);
    check_eq("tdo_en", TDO_EN, m_en);
    @(posedge TCK);
    model_posedge(tms, tdi);
    #1;
    check_post();
  endtask

  task automatic do_trst();
    TRST = 1'b1;
    #1;
    check_reset_outputs("trst");
    model_reset();
    #1;
    TRST = 1'b0;
  endtask

  task automatic goto_rti();
    repeat (5) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // From RTI: capture, shift op LSB first, update, back to RTI.
  task automatic load_ir(input logic [3:0] op);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, op[i]);
      check_eq("ir_capture_tdo", obs_tdo, exp_q.pop_front());
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // From RTI: capture, shift n bits, update, back to RTI. mode 1 checks exp_q, mode 2 ID follow.
  task automatic shift_dr(input int n, input logic [31:0] data, input int mode);
    cap_cnt = 0; shd_cnt = 0; upd_cnt = 0;
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, data[i]);
      if (mode == 1 && exp_q.size() > 0) check_eq("dr_tdo_q", obs_tdo, exp_q.pop_front());
      if (mode == 2) check_eq("id_follow", obs_tdo, ID_REG_TDO);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] data;
    TRST = 1'b1; TMS = 1'b1; TDI = 1'b0;
    ID_REG_TDO = 1'b0; USERCODE_REG_TDO = 1'b0; BSR_TDO = 1'b0; BIST_TDO = 1'b0;
    cap_cnt = 0; shd_cnt = 0; upd_cnt = 0;
    repeat (2) @(posedge TCK);
    #1;
    check_reset_outputs("por");
    model_reset();
    TRST = 1'b0;

    // TMS=1 in TLR holds TLR with IDCODE selected
    repeat (3) tick(1'b1, 1'b0);
    check_eq("tlr_hold_idcode", IDCODE_SELECT, 1'b1);
    tick(1'b0, 1'b0);

    // Load USERCODE; capture pattern appears on TDO
    load_ir(4'h4);
    check_eq("usercode_sel", USERCODE_SELECT, 1'b1);
    check_eq("usercode_only", dut_sel(), 7'b0010000);

    // Five TMS=1 from PAUSE_IR reach TLR; next posedge in TLR forces IDCODE
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    repeat (5) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check_eq("five_tms_idcode", IDCODE_SELECT, 1'b1);

    // TRST mid Shift-DR
    load_ir(4'h4);
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b1);
    do_trst();
    tick(1'b0, 1'b0);

    // Bypass via all-ones opcode: one-bit delay, first bit 0
    load_ir(4'hF);
    check_eq("ones_no_sel", dut_sel(), 7'b0000000);
    data = 32'hA5;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 7; i++) exp_q.push_back(data[i]);
    shift_dr(8, data, 1);

    // IDCODE: single capture, eight shifts, TDO follows ID_REG_TDO
    load_ir(4'h1);
    shift_dr(8, 32'h3C, 2);
    check_eq("cap_cycles", cap_cnt, 1);
    check_eq("shift_cycles", shd_cnt, 8);

    // Undefined opcode 9 -> bypass, update still pulses once
    load_ir(4'h9);
    check_eq("op9_no_sel", dut_sel(), 7'b0000000);
    data = $urandom;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 7; i++) exp_q.push_back(data[i]);
    shift_dr(8, data, 1);
    check_eq("op9_upd_cycles", upd_cnt, 1);

    // Randomized instruction loads and DR scans
    repeat (40) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      load_ir(op);
      check_eq("rand_sel", dut_sel(), sel_of(op));
      shift_dr($urandom_range(1, 12), $urandom, 0);
    end

    // Randomized TMS walk with occasional TRST
    repeat (400) begin
      if ($urandom_range(0, 49) == 0) do_trst();
      tick($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
    end
    goto_rti();
    check_eq("final_idcode", IDCODE_SELECT, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
